// File: rtl/ram_pkg.sv
// Shared constants and state encoding for the RAM read streamer.
package ram_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 4;
    localparam int RD_LAT     = 1;
    localparam int DEPTH      = 2 ** ADDR_W;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry FIFO absorbing RAM read data so that no returning word is lost
// while the consumer stalls. Push while full is accepted only with a pop.
module ram_rd_skid_fifo
    import ram_pkg::*;
#(
    parameter int W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full_o    = (count_q == 2'd2);
    assign empty_o   = (count_q == 2'd0);
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop_i && !empty_o;
    assign push_ok_s = push_i && (!full_o || pop_ok_s);

    // Storage, pointers and occupancy; simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ram_read_streamer.sv
// Burst read engine: issues reads to the RAM under a credit limit, tracks the
// RAM latency with a valid shift register and streams words from a skid FIFO.
module ram_read_streamer
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o
);

    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_last_q, rd_last_d;
    logic [RD_LAT-1:0]   vld_q;
    logic [RD_LAT-1:0]   vlast_q;
    logic                busy_q;
    logic                done_q;

    logic [DATA_W:0]     head_s;
    logic [1:0]          fifo_count_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic                pop_s;
    logic [2:0]          pend_s;
    logic                credit_ok_s;

    assign pop_s = !fifo_empty_s && m_ready_i;

    // Words that will still occupy the pipeline or FIFO after this cycle's pop.
    always_comb begin
        pend_s = {2'b00, rd_en_q} + {1'b0, fifo_count_s};
        for (int i = 0; i < RD_LAT; i++) begin
            pend_s = pend_s + {2'b00, vld_q[i]};
        end
        pend_s      = pend_s - {2'b00, pop_s};
        credit_ok_s = (pend_s < 3'd2) && !(fifo_full_s && !pop_s);
    end

    // Next-state, address/remaining counters and read issue.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_last_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d = READ;
                        addr_d  = base_addr_i;
                        rem_d   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (rem_q == '0) begin
                    state_d = DRAIN;
                end else if (credit_ok_s) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    rd_last_d = (rem_q == REM_ONE);
                    addr_d    = addr_q + ADDR_ONE;
                    rem_d     = rem_q - REM_ONE;
                end else begin
                    state_d = READ;
                end
            end
            DRAIN: begin
                if (!rd_en_q && (vld_q == '0) &&
                    (fifo_empty_s || (fifo_count_s == 2'd1 && pop_s))) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters, registered RAM port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_last_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_last_q <= rd_last_d;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_q == DONE);
        end
    end

    // RAM latency tracker: marks the cycle each issued read's data is at rd_data_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            vlast_q <= '0;
        end else begin
            vld_q[0]   <= rd_en_q;
            vlast_q[0] <= rd_last_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                vlast_q[i] <= vlast_q[i-1];
            end
        end
    end

    ram_rd_skid_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (vld_q[RD_LAT-1]),
        .push_data_i ({vlast_q[RD_LAT-1], rd_data_i}),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_count_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign m_valid_o = !fifo_empty_s;
    assign m_data_o  = head_s[DATA_W-1:0];
    assign m_last_o  = !fifo_empty_s && head_s[DATA_W];

endmodule

// File: tb/tb_ram_read_streamer.sv
// Bench: dual-port RAM model plus streamer, checked against a queue-based model.
module tb_ram_read_streamer;
    import ram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  base_addr = 4'd0;
    logic [4:0]  len = 5'd0;
    logic        busy, done, rd_en, m_valid, m_last;
    logic        m_ready = 1'b1;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data, m_data;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_data = 8'd0;
    logic [7:0]  mem [16];

    int checks = 0, errors = 0;
    int cyc = 0, start_cyc = 0, beats = 0, done_cnt = 0, issued = 0, accepted = 0;
    int rpat = 0;
    bit rmode = 1'b0, first_pending = 1'b0, stall_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [3:0] exp_addr[$];
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    logic [7:0] img [16];
    logic [7:0] acc_log[$];
    logic [3:0] addr_log[$];

    always #5 clk = ~clk;

    // RAM write port and RAM_LAT=1 read port
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    ram_read_streamer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base_addr), .len_i(len),
        .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
        .rd_data_i(rd_data), .m_data_o(m_data), .m_valid_o(m_valid),
        .m_ready_i(m_ready), .m_last_o(m_last)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Expected burst contents computed from the address arithmetic and RAM image
    task automatic launch(input int b, input int l);
        int n;
        n = (l > 16) ? 16 : l;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(4'((b + i) % 16));
            exp_data.push_back(img[(b + i) % 16]);
            exp_last.push_back(i == n - 1);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                issued++;
                if (exp_addr.size() == 0) chk("rd_en_unexpected", 32'd1, 32'd0);
                else chk("rd_addr", {28'd0, rd_addr}, {28'd0, exp_addr.pop_front()});
                addr_log.push_back(rd_addr);
                chk("credit", (issued - accepted <= 2) ? 32'd1 : 32'd0, 32'd1);
            end
            if (stall_prev) begin
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_data", {24'd0, m_data}, {24'd0, prev_data});
                chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            if (m_valid) begin
                if (first_pending) begin
                    chk("first_latency", cyc - start_cyc, 32'd3);
                    first_pending = 1'b0;
                end
                if (exp_data.size() == 0) begin
                    chk("m_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("m_data", {24'd0, m_data}, {24'd0, exp_data[0]});
                    chk("m_last", {31'd0, m_last}, {31'd0, exp_last[0]});
                    if (m_ready) begin
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                        accepted++;
                        beats++;
                        acc_log.push_back(m_data);
                    end
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (done) done_cnt++;
        end
    end

    task automatic set_ready();
        if (rmode) begin
            m_ready = (rpat % 4 == 0) || (rpat % 4 == 3);
            rpat++;
        end else begin
            m_ready = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        set_ready();
    endtask

    task automatic start_burst(input int b, input int l, input bit model);
        @(posedge clk); #1;
        set_ready();
        start = 1'b1; base_addr = 4'(b); len = 5'(l);
        if (model) launch(b, l);
        @(posedge clk); #1;
        start_cyc = cyc;
        if (model && l != 0) first_pending = 1'b1;
        start = 1'b0;
        set_ready();
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 400) begin step(); t++; end
        if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
        repeat (3) step();
    endtask

    task automatic run_burst(input int b, input int l, input int n);
        int d0;
        beats = 0; acc_log.delete(); addr_log.delete(); rpat = 0;
        d0 = done_cnt;
        start_burst(b, l, 1'b1);
        wait_done(d0);
        chk("beats", beats, n);
        chk("done_once", done_cnt - d0, 32'd1);
        chk("model_drained", exp_data.size() + exp_addr.size(), 32'd0);
    endtask

    initial begin
        int d0;
        // reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        // preload mem[i] = i through the write port
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'(i); img[i] = 8'(i);
        end
        @(posedge clk); #1 wr_en = 1'b0;

        // 1: full burst, ready held high
        run_burst(0, 16, 16);
        chk("t1_first", {24'd0, acc_log[0]}, 32'd0);
        chk("t1_last", {24'd0, acc_log[15]}, 32'd15);

        // 2: ready toggling 1,0,0,1
        rmode = 1'b1;
        run_burst(0, 16, 16);
        chk("t2_word9", {24'd0, acc_log[9]}, 32'd9);
        rmode = 1'b0;

        // 3: wrap
        run_burst(14, 4, 4);
        chk("t3_addr0", {28'd0, addr_log[0]}, 32'd14);
        chk("t3_addr2", {28'd0, addr_log[2]}, 32'd0);
        chk("t3_data1", {24'd0, acc_log[1]}, 32'd15);
        chk("t3_data3", {24'd0, acc_log[3]}, 32'd1);

        // 4: len = 0 no-op, done two cycles after start
        d0 = done_cnt;
        start_burst(5, 0, 1'b1);
        @(negedge clk);
        chk("len0_done_early", {31'd0, done}, 32'd0);
        chk("len0_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("len0_done", {31'd0, done}, 32'd1);
        repeat (4) step();
        chk("len0_done_once", done_cnt - d0, 32'd1);
        // len = 20 clamps to 16
        run_burst(0, 20, 16);

        // 5: start while busy is ignored
        beats = 0; acc_log.delete(); d0 = done_cnt;
        start_burst(0, 16, 1'b1);
        for (int t = 0; t < 200 && beats < 5; t++) step();
        chk("t5_busy", {31'd0, busy}, 32'd1);
        start = 1'b1; base_addr = 4'd8; len = 5'd2;
        step();
        start = 1'b0;
        wait_done(d0);
        chk("t5_beats", beats, 32'd16);
        chk("t5_word6", {24'd0, acc_log[6]}, 32'd6);
        chk("t5_done_once", done_cnt - d0, 32'd1);

        // 6: reset mid-burst
        beats = 0; d0 = done_cnt;
        start_burst(0, 16, 1'b1);
        for (int t = 0; t < 200 && beats < 7; t++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("arst_m_last", {31'd0, m_last}, 32'd0);
        chk("arst_m_data", {24'd0, m_data}, 32'd0);
        exp_addr.delete(); exp_data.delete(); exp_last.delete();
        issued = 0; accepted = 0; stall_prev = 1'b0; first_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) step();
        chk("arst_no_done", done_cnt - d0, 32'd0);
        run_burst(3, 2, 2);
        chk("t6_data0", {24'd0, acc_log[0]}, 32'd3);
        chk("t6_data1", {24'd0, acc_log[1]}, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
